// File: rtl/line_bank_scheduler_pkg.sv
// Shared definitions for the PAL->HD line buffer: scheduler state encoding,
// default geometry and the bank base address helper used by the address counters.
package line_bank_scheduler_pkg;

  localparam int NBANKS_DEF  = 4;
  localparam int BANK_AW_DEF = 11;
  localparam int ADDR_W_DEF  = 13;
  localparam int BANK_W_DEF  = $clog2(NBANKS_DEF);
  localparam int FILL_W_DEF  = BANK_W_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Callers truncate the result to their BRAM address width.
  function automatic logic [31:0] bank_base(input logic [31:0] bank, input int aw,
                                            input logic [31:0] offset);
    return (bank << aw) + offset;
  endfunction

endpackage

// File: rtl/line_bank_scheduler_ring_ptr.sv
// Wrap-around bank counter; clear has priority over advance.
module lbs_ring_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        value <= '0;
    else if (clear)   value <= '0;
    else if (advance) value <= value + W'(1);
  end

endmodule

// File: rtl/line_bank_scheduler.sv
// Line bank scheduler: tracks PAL write bank, HD read bank and fill level,
// repeating lines on underrun and overwriting the newest line on overrun.
module line_bank_scheduler
  import line_bank_scheduler_pkg::*;
#(
  parameter int NBANKS      = NBANKS_DEF,
  parameter int BANK_AW     = BANK_AW_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int PRIME_LINES = 2,
  parameter int OFFSET_HZ   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_frame_start,
  input  logic                      i_wr_line_start,
  input  logic                      i_rd_line_start,
  output logic [ADDR_W-1:0]         o_wr_base,
  output logic [ADDR_W-1:0]         o_rd_base,
  output logic [$clog2(NBANKS)-1:0] o_wr_bank,
  output logic [$clog2(NBANKS)-1:0] o_rd_bank,
  output logic [$clog2(NBANKS):0]   o_fill,
  output logic                      o_rd_valid,
  output logic                      o_repeat,
  output logic                      o_drop,
  output logic [1:0]                o_state
);

  localparam int BW = $clog2(NBANKS);
  localparam int FW = BW + 1;

  state_t        state;
  logic [FW-1:0] fill;
  logic          wr_open;

  logic          active, wr_done, full, rd_frees, wr_adv, drop_n;
  logic          prime_go, rd_adv, rep_n;
  logic [FW-1:0] fill_w, fill_n;
  logic [BW-1:0] wr_bank_n, rd_bank_n;

  // Write is resolved first against the pre-cycle fill; the read then sees fill_w.
  // A read in RUN always frees a bank when full, so the write advances instead of dropping.
  always_comb begin
    active    = (state != ST_IDLE);
    wr_done   = active && i_wr_line_start && wr_open;
    full      = (state == ST_PRIME) ? (fill == FW'(NBANKS - 1)) : (fill == FW'(NBANKS - 2));
    rd_frees  = (state == ST_RUN) && i_rd_line_start;
    wr_adv    = wr_done && (!full || rd_frees);
    drop_n    = wr_done && full && !rd_frees;
    fill_w    = fill + FW'(wr_adv);
    prime_go  = (state == ST_PRIME) && i_rd_line_start && (fill_w >= FW'(PRIME_LINES));
    rd_adv    = (state == ST_RUN) && i_rd_line_start && (fill_w != '0);
    rep_n     = (state == ST_RUN) && i_rd_line_start && (fill_w == '0);
    fill_n    = (prime_go || rd_adv) ? fill_w - FW'(1) : fill_w;
    wr_bank_n = i_frame_start ? '0 : (wr_adv ? o_wr_bank + BW'(1) : o_wr_bank);
    rd_bank_n = i_frame_start ? '0 : (rd_adv ? o_rd_bank + BW'(1) : o_rd_bank);
  end

  lbs_ring_ptr #(.W(BW)) u_wr_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_frame_start),
    .advance (wr_adv),
    .value   (o_wr_bank)
  );

  lbs_ring_ptr #(.W(BW)) u_rd_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_frame_start),
    .advance (rd_adv),
    .value   (o_rd_bank)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      fill       <= '0;
      wr_open    <= 1'b0;
      o_rd_valid <= 1'b0;
      o_repeat   <= 1'b0;
      o_drop     <= 1'b0;
      o_wr_base  <= '0;
      o_rd_base  <= ADDR_W'(OFFSET_HZ);
    end else begin
      o_wr_base <= ADDR_W'(bank_base(32'(wr_bank_n), BANK_AW, 32'd0));
      o_rd_base <= ADDR_W'(bank_base(32'(rd_bank_n), BANK_AW, 32'(OFFSET_HZ)));
      if (i_frame_start) begin
        state      <= ST_PRIME;
        fill       <= '0;
        wr_open    <= 1'b0;
        o_rd_valid <= 1'b0;
        o_repeat   <= 1'b0;
        o_drop     <= 1'b0;
      end else begin
        if (active && i_wr_line_start && !wr_open) wr_open <= 1'b1;
        fill     <= fill_n;
        o_repeat <= rep_n;
        o_drop   <= drop_n;
        if (prime_go) begin
          state      <= ST_RUN;
          o_rd_valid <= 1'b1;
        end
      end
    end
  end

  assign o_fill  = fill;
  assign o_state = state;

endmodule

// File: tb/tb_line_bank_scheduler.sv
// Directed bench for line_bank_scheduler: driver pushes hand-computed expected
// outputs per cycle, a monitor pops and compares one clock later.
module tb_line_bank_scheduler;

  localparam int W = 38;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_frame_start = 1'b0;
  logic        i_wr_line_start = 1'b0;
  logic        i_rd_line_start = 1'b0;
  logic [12:0] o_wr_base, o_rd_base;
  logic [1:0]  o_wr_bank, o_rd_bank;
  logic [2:0]  o_fill;
  logic        o_rd_valid, o_repeat, o_drop;
  logic [1:0]  o_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  line_bank_scheduler #(
    .NBANKS(4), .BANK_AW(11), .ADDR_W(13), .PRIME_LINES(2), .OFFSET_HZ(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_frame_start   (i_frame_start),
    .i_wr_line_start (i_wr_line_start),
    .i_rd_line_start (i_rd_line_start),
    .o_wr_base       (o_wr_base),
    .o_rd_base       (o_rd_base),
    .o_wr_bank       (o_wr_bank),
    .o_rd_bank       (o_rd_bank),
    .o_fill          (o_fill),
    .o_rd_valid      (o_rd_valid),
    .o_repeat        (o_repeat),
    .o_drop          (o_drop),
    .o_state         (o_state)
  );

  // Drive one cycle of inputs at the falling edge and queue the expected outputs
  // seen after the following rising edge.
  task automatic step(input logic rs, input logic fs, input logic wr, input logic rd,
                      input logic [1:0] st, input logic [1:0] wb, input logic [1:0] rb,
                      input logic [2:0] f, input logic v, input logic rp, input logic dr,
                      input string nm);
    logic [12:0] wbase, rbase;
    @(negedge clk);
    reset           = rs;
    i_frame_start   = fs;
    i_wr_line_start = wr;
    i_rd_line_start = rd;
    wbase = {wb, 11'b0};
    rbase = {rb, 11'b0} + 13'd16;
    exp_q.push_back({st, wb, rb, f, v, rp, dr, wbase, rbase});
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [W-1:0] act, exp_v;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act   = {o_state, o_wr_bank, o_rd_bank, o_fill, o_rd_valid, o_repeat, o_drop,
                 o_wr_base, o_rd_base};
        n_cmp++;
        if (act !== exp_v) begin
          n_bad++;
          $display("FAIL %s: got st=%0d wb=%0d rb=%0d fill=%0d v=%b rep=%b drop=%b wbase=%h rbase=%h, want st=%0d wb=%0d rb=%0d fill=%0d v=%b rep=%b drop=%b wbase=%h rbase=%h",
                   nm, act[37:36], act[35:34], act[33:32], act[31:29], act[28], act[27], act[26],
                   act[25:13], act[12:0], exp_v[37:36], exp_v[35:34], exp_v[33:32], exp_v[31:29],
                   exp_v[28], exp_v[27], exp_v[26], exp_v[25:13], exp_v[12:0]);
        end
      end
    end
  end

  initial begin : stim
    //    rs fs wr rd  st wb rb f  v rp dr
    step(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, "reset_state");
    step(0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, "idle_ignore_wr");
    step(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, "idle_ignore_rd");
    step(0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, "frame_start");
    step(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, "first_wr_opens");
    step(0, 0, 1, 0,  1, 1, 0, 1, 0, 0, 0, "prime_wr1");
    step(0, 0, 0, 1,  1, 1, 0, 1, 0, 0, 0, "prime_rd_too_early");
    step(0, 0, 1, 0,  1, 2, 0, 2, 0, 0, 0, "prime_wr2");
    step(0, 0, 0, 1,  2, 2, 0, 1, 1, 0, 0, "prime_to_run");
    step(0, 0, 0, 1,  2, 2, 1, 0, 1, 0, 0, "run_rd");
    step(0, 0, 0, 1,  2, 2, 1, 0, 1, 1, 0, "underrun_repeat");
    step(0, 0, 0, 0,  2, 2, 1, 0, 1, 0, 0, "repeat_one_cycle");
    step(0, 0, 1, 0,  2, 3, 1, 1, 1, 0, 0, "run_wr_a");
    step(0, 0, 1, 0,  2, 0, 1, 2, 1, 0, 0, "run_wr_full_wrap");
    step(0, 0, 1, 0,  2, 0, 1, 2, 1, 0, 1, "overrun_drop");
    step(0, 0, 1, 1,  2, 1, 2, 2, 1, 0, 0, "full_wr_rd_no_drop");
    step(0, 0, 0, 1,  2, 1, 3, 1, 1, 0, 0, "rd_bank3_base");
    step(0, 0, 0, 1,  2, 1, 0, 0, 1, 0, 0, "rd_wrap");
    step(0, 0, 1, 0,  2, 2, 0, 1, 1, 0, 0, "wrap_wr");
    step(0, 0, 1, 1,  2, 3, 1, 1, 1, 0, 0, "wrap_wr_rd");
    step(0, 0, 1, 0,  2, 0, 1, 2, 1, 0, 0, "wrap_wr_wrap");
    step(0, 0, 0, 1,  2, 0, 2, 1, 1, 0, 0, "wrap_rd_a");
    step(0, 0, 0, 1,  2, 0, 3, 0, 1, 0, 0, "wrap_rd_b");
    step(0, 0, 1, 1,  2, 1, 0, 0, 1, 0, 0, "empty_wr_rd_same");
    step(0, 0, 0, 1,  2, 1, 0, 0, 1, 1, 0, "repeat_after_wrap");
    step(0, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0, "frame_beats_lines");
    step(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, "reopen_after_frame");
    step(0, 0, 1, 0,  1, 1, 0, 1, 0, 0, 0, "refill_1");
    step(0, 0, 1, 0,  1, 2, 0, 2, 0, 0, 0, "refill_2");
    step(0, 0, 0, 1,  2, 2, 0, 1, 1, 0, 0, "rerun");
    step(0, 0, 1, 0,  2, 3, 0, 2, 1, 0, 0, "run_fill2");
    step(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, "reset_mid_run");
    step(0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, "post_reset_wr_ignored");
    step(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, "post_reset_rd_ignored");
    step(0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, "frame_again");
    step(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, "open_again");
    step(0, 0, 1, 0,  1, 1, 0, 1, 0, 0, 0, "prime_fill1");
    step(0, 0, 1, 0,  1, 2, 0, 2, 0, 0, 0, "prime_fill2");
    step(0, 0, 1, 0,  1, 3, 0, 3, 0, 0, 0, "prime_fill3");
    step(0, 0, 1, 0,  1, 3, 0, 3, 0, 0, 1, "prime_full_drop");
    step(0, 0, 0, 0,  1, 3, 0, 3, 0, 0, 0, "drop_one_cycle");

    @(negedge clk);
    i_frame_start   = 1'b0;
    i_wr_line_start = 1'b0;
    i_rd_line_start = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
